// File: rtl/pixel_streamer_pkg.sv
// Shared definitions for the pixel streamer: FSM state codes, frame size
// defaults and the layout of one output FIFO entry {eof, sof, data}.
package pixel_streamer_pkg;

    // FSM state codes
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DRAIN     = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_FLUSH     = 3'd5;

    // Default frame geometry and the resulting pixel count
    localparam int DEF_WIDTH   = 320;
    localparam int DEF_HEIGHT  = 240;
    localparam int PIXEL_COUNT = DEF_WIDTH * DEF_HEIGHT;

    // FIFO entry field widths: {eof, sof, data[7:0]}
    localparam int PIX_BITS   = 4;
    localparam int DATA_BITS  = 2 * PIX_BITS;
    localparam int ENTRY_BITS = DATA_BITS + 2;

    // Pixel count for an arbitrary frame geometry
    function automatic int pixel_count(input int w, input int h);
        return w * h;
    endfunction

    // Assemble one FIFO entry from its fields
    function automatic logic [ENTRY_BITS-1:0] pack_entry(
        input logic                 eof,
        input logic                 sof,
        input logic [DATA_BITS-1:0] data
    );
        return {eof, sof, data};
    endfunction

endpackage

// File: rtl/pixel_streamer_fifo.sv
// Registered first-word-fall-through FIFO. The head entry is presented
// combinationally from the storage registers while occupancy is non-zero,
// and outputs read as zero when empty.
module pixel_fifo #(
    parameter int WIDTH_BITS = 10,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH_BITS-1:0]        push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH_BITS-1:0]        pop_data_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_en_s;
    logic                  rd_en_s;

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == {CW{1'b0}});
    assign wr_en_s = push_i && !full_s;
    assign rd_en_s = pop_i && !empty_s;

    // Storage, pointers and occupancy; push+pop together keeps occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH_BITS{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o    = !empty_s;
    assign pop_data_o = empty_s ? {WIDTH_BITS{1'b0}} : mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/pixel_streamer.sv
// Pixel streamer: sequences a Mandelbrot engine one pixel at a time, packs
// pixel pairs into bytes (even pixel low nibble) and streams them through a
// small FIFO with sof/eof framing. Engine runs are throttled on FIFO space so
// a push can never hit a full FIFO.
module pixel_streamer
    import pixel_streamer_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic        eng_run,
    input  logic        eng_running,
    input  logic [3:0]  eng_ctr,
    input  logic        eng_finished,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int PIX_TOTAL = pixel_count(WIDTH, HEIGHT);
    localparam int CNT_W     = (PIX_TOTAL > 2) ? $clog2(PIX_TOTAL) : 1;
    localparam int OCC_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIX_TOTAL - 1);

    logic [2:0]            state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PIX_BITS-1:0]   nib_q, nib_d;

    logic                  push_s;
    logic [ENTRY_BITS-1:0] push_data_s;
    logic                  pop_s;
    logic [ENTRY_BITS-1:0] head_s;
    logic                  fifo_valid_s;
    logic [OCC_W-1:0]      fifo_count_s;
    logic                  run_ok_s;
    logic                  is_last_s;

    assign run_ok_s  = (fifo_count_s < OCC_W'(FIFO_DEPTH));
    assign is_last_s = (cnt_q == LAST_IDX);
    assign pop_s     = fifo_valid_s && out_ready;

    // Next-state logic: frame sequencing, pixel capture and byte packing
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;
        nib_d       = nib_q;
        push_s      = 1'b0;
        push_data_s = {ENTRY_BITS{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRAIN;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    nib_d   = {PIX_BITS{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Let any pixel left over from an earlier reset complete
                if (!eng_running) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RUN: begin
                if (run_ok_s) begin
                    state_d = ST_WAIT_BUSY;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT_BUSY: begin
                if (eng_running) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!eng_running) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!cnt_q[0]) begin
                        nib_d = eng_ctr;
                    end else begin
                        push_s      = 1'b1;
                        push_data_s = pack_entry(is_last_s,
                                                 cnt_q == CNT_W'(1),
                                                 {eng_ctr, nib_q});
                    end
                    // Engine's own end-of-frame flag must agree with our count
                    if (eng_finished != is_last_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    state_d = is_last_s ? ST_FLUSH : ST_RUN;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_FLUSH: begin
                if (pop_s && head_s[ENTRY_BITS-1]) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            nib_q   <= {PIX_BITS{1'b0}};
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            nib_q   <= nib_d;
        end
    end

    pixel_fifo #(
        .WIDTH_BITS (ENTRY_BITS),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .pop_data_o  (head_s),
        .valid_o     (fifo_valid_s),
        .count_o     (fifo_count_s)
    );

    // Run is driven straight from state so the engine restarts with minimal gap
    assign eng_run    = (state_q == ST_RUN) && run_ok_s;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign out_valid  = fifo_valid_s;
    assign out_data   = head_s[DATA_BITS-1:0];
    assign out_sof    = head_s[DATA_BITS];
    assign out_eof    = head_s[DATA_BITS+1];

endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer with a 4x2 frame and a behavioural
// Mandelbrot engine model.
module tb_pixel_streamer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, frame_done, frame_err, eng_run;
    logic       eng_running;
    logic [3:0] eng_ctr = 4'h0;
    logic       eng_finished = 1'b0;
    logic [7:0] out_data;
    logic       out_sof, out_eof, out_valid;
    logic       out_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int run_cnt  = 0;

    logic [9:0] exp_q [$];

    // engine model state
    logic m_running = 1'b0;
    int   m_k = 0;
    int   m_next = 0;
    int   m_left = 0;
    int   fin_pixel = 7;
    int   restart_req = 0;
    int   restart_seen = 0;

    logic       hold_pending = 1'b0;
    logic [9:0] held = 10'h000;
    logic       tog_en = 1'b0;

    pixel_streamer #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .eng_run      (eng_run),
        .eng_running  (eng_running),
        .eng_ctr      (eng_ctr),
        .eng_finished (eng_finished),
        .out_data     (out_data),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    assign eng_running = m_running;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Engine model: running rises after run, pixel k runs k+2 cycles, ctr=k+1
    always @(posedge clk) begin
        int k_sel;
        if (m_running) begin
            if (m_left == 1) begin
                m_running    <= 1'b0;
                eng_ctr      <= 4'(m_k + 1);
                eng_finished <= (m_k == fin_pixel);
            end
            m_left <= m_left - 1;
        end else if (eng_run) begin
            if (restart_req != restart_seen) begin
                k_sel = 0;
                restart_seen <= restart_req;
            end else begin
                k_sel = m_next;
            end
            m_running <= 1'b1;
            m_k       <= k_sel;
            m_left    <= k_sel + 2;
            m_next    <= (k_sel + 1) % 8;
        end
    end

    // Monitor: scoreboard pops, hold stability, run legality, occupancy bound
    always @(negedge clk) begin
        if (reset) begin
            hold_pending <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", {out_eof, out_sof, out_data});
                end else begin
                    check("byte {eof,sof,data}", {22'd0, out_eof, out_sof, out_data}, {22'd0, exp_q.pop_front()});
                end
            end
            if (hold_pending) begin
                check("hold_stable", {21'd0, out_valid, out_eof, out_sof, out_data}, {21'd0, 1'b1, held});
            end
            hold_pending <= out_valid && !out_ready;
            held         <= {out_eof, out_sof, out_data};
            if (frame_done) done_cnt++;
            if (eng_run) begin
                run_cnt++;
                check("run_while_engine_running", {31'd0, m_running}, 32'd0);
            end
            if (dut.fifo_count_s > 3'd4) begin
                check("occupancy_bound", {29'd0, dut.fifo_count_s}, 32'd4);
            end
        end
    end

    task automatic push_frame_expect();
        exp_q.push_back({1'b0, 1'b1, 8'h21});
        exp_q.push_back({1'b0, 1'b0, 8'h43});
        exp_q.push_back({1'b0, 1'b0, 8'h65});
        exp_q.push_back({1'b1, 1'b0, 8'h87});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int t;
        d0 = done_cnt;
        t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_done_timeout: got no frame_done, expected one within %0d cycles", budget);
        end
        repeat (5) @(posedge clk);
        #1;
        check("frame_done_pulses", done_cnt - d0, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_eng_run"},    {31'd0, eng_run},    32'd0);
        check({tag, "_out_valid"},  {31'd0, out_valid},  32'd0);
        check({tag, "_sof_eof"},    {30'd0, out_sof, out_eof}, 32'd0);
        check({tag, "_out_data"},   {24'd0, out_data},   32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int d0;
        int t;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;

        // 1: plain frame with sink always ready
        push_frame_expect();
        pulse_start();
        wait_done(1000);
        check("t1_frame_err", {31'd0, frame_err}, 32'd0);

        // 2: sink stalled for the whole frame, FIFO fills then drains
        out_ready = 1'b0;
        push_frame_expect();
        r0 = run_cnt;
        pulse_start();
        repeat (300) @(posedge clk);
        #1;
        check("t2_runs_before_release", run_cnt - r0, 32'd8);
        check("t2_occupancy", {29'd0, dut.fifo_count_s}, 32'd4);
        check("t2_head_valid", {31'd0, out_valid}, 32'd1);
        check("t2_head_data", {24'd0, out_data}, 32'h21);
        check("t2_head_sof", {31'd0, out_sof}, 32'd1);
        check("t2_still_busy", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        wait_done(1000);

        // 3: engine flags finished early on pixel 5
        fin_pixel = 5;
        push_frame_expect();
        pulse_start();
        wait_done(1000);
        check("t3_frame_err", {31'd0, frame_err}, 32'd1);
        fin_pixel = 7;

        // 4: reset while waiting on pixel 3, then restart through DRAIN
        push_frame_expect();
        pulse_start();
        check("t4_err_cleared_on_start", {31'd0, frame_err}, 32'd0);
        t = 0;
        while (!(m_running && m_k == 3) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("t4_reached_pixel3", {31'd0, m_running}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("t4_midreset");
        check("t4_engine_left_running", {31'd0, eng_running}, 32'd1);
        exp_q.delete();
        restart_req++;
        reset = 1'b0;
        push_frame_expect();
        pulse_start();
        wait_done(1000);
        check("t4_frame_err", {31'd0, frame_err}, 32'd0);

        // 5: extra start pulses while busy are ignored
        d0 = done_cnt;
        push_frame_expect();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_done(1000);
        repeat (30) @(posedge clk);
        #1;
        check("t5_total_done", done_cnt - d0, 32'd1);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);

        // 6: sink ready toggling every cycle
        push_frame_expect();
        tog_en = 1'b1;
        fork
            begin
                while (tog_en) begin
                    @(posedge clk);
                    #1 out_ready = ~out_ready;
                end
            end
        join_none
        pulse_start();
        wait_done(1000);
        tog_en = 1'b0;
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
        check("t6_frame_err", {31'd0, frame_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_streamer.md
PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 Parameters SHALL be: WIDTH, default 320, pixels per line; HEIGHT, default 240, lines per frame; FIFO_DEPTH, default 4, output byte FIFO entries (power of 2, >=2); WIDTH*HEIGHT SHALL be even.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  request one frame
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse, last byte accepted
- frame_err  out  1  sticky, engine frame length mismatch
- eng_run  out  1  run pulse to Mandelbrot engine
- eng_running  in  1  engine running
- eng_ctr  in  4  engine ctr_out
- eng_finished  in  1  engine finished
- out_data  out  8  packed pixels: even pixel in [3:0], odd pixel in [7:4]
- out_sof  out  1  qualifies first byte of frame
- out_eof  out  1  qualifies last byte of frame
- out_valid  out  1  byte available
- out_ready  in  1  sink accepts; transfer when valid&&ready

Function
REQ-004 FSM states SHALL be IDLE, DRAIN, RUN, WAIT_BUSY, WAIT_DONE, FLUSH.
REQ-005 IDLE: start=1 -> DRAIN; busy asserts the cycle after start is sampled; start while busy SHALL be ignored.
REQ-006 DRAIN: wait until eng_running=0, then -> RUN; this absorbs an engine pixel left running by a reset.
REQ-007 RUN: eng_run=1 for exactly one cycle, only if FIFO occupancy < FIFO_DEPTH; else hold in RUN with eng_run=0; then -> WAIT_BUSY.
REQ-008 WAIT_BUSY: eng_running=1 -> WAIT_DONE.
REQ-009 WAIT_DONE: first cycle with eng_running=0 SHALL capture eng_ctr and eng_finished.
- If the pixel count is not the last, go -> RUN.
- If it is the last, go -> FLUSH.
REQ-010 A 17-bit pixel counter (width clog2(WIDTH*HEIGHT)) SHALL clear on start and increment per captured pixel.
REQ-011 Even-index pixels SHALL be held in a nibble register. On each odd-index capture, {odd, held} SHALL be pushed as one FIFO entry in the same cycle.
- out_sof=1 on the entry containing pixels 0/1.
- out_eof=1 on the entry containing the last two pixels.
REQ-012 Last pixel is index WIDTH*HEIGHT-1. If eng_finished disagrees with this (finished=1 earlier, or finished=0 on the last pixel), frame_err SHALL set. Frame length is governed by the counter, not eng_finished.
REQ-013 FIFO SHALL be 10 bits wide {eof,sof,data}, registered, first-word fall-through. out_valid rises the cycle after the first push into an empty FIFO.
REQ-014 Push into a full FIFO SHALL be impossible by construction (REQ-007). Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-015 out_data/out_sof/out_eof SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 FLUSH: on the transfer of the eof byte, frame_done pulses for one cycle, busy deasserts the same cycle, and the FSM goes -> IDLE.
REQ-017 Pipeline throughput SHALL be one pixel per engine iteration sequence; the block SHALL add no more than 2 idle cycles between engine pixels when the FIFO is not full.

Reset
REQ-018 On reset the following SHALL apply:
- State -> IDLE.
- busy, frame_done, eng_run, out_valid, out_sof, out_eof = 0; out_data = 0.
- FIFO emptied; pixel counter and nibble register cleared.
REQ-019 frame_err SHALL clear on reset and on accepted start.
REQ-020 Reset mid-frame SHALL discard all buffered bytes. The next frame SHALL begin via DRAIN, so the engine restarts from its finished state.

Structure
REQ-021 A shared package SHALL hold the FSM state enum, the PIXEL_COUNT constant (WIDTH*HEIGHT), and the FIFO entry field widths.
REQ-022 The FIFO SHALL be one sub-module, pixel_fifo (parameters WIDTH_BITS=10, DEPTH), with occupancy output; everything else SHALL be inline.

Verification
REQ-023 The bench SHALL use WIDTH=4, HEIGHT=2 with a behavioural engine model (running rises 1 cycle after run, pixel k takes k+2 cycles, ctr=k+1, finished on pixel 7). It SHALL cover:
- Frame, out_ready=1 -> bytes 0x21,0x43,0x65,0x87; sof on byte 0, eof on byte 3; frame_done one pulse; frame_err=0.
- out_ready=0 for the whole frame -> exactly 4 bytes queued, eng_run stops after pixel 7; out_data=0x21 held; release -> same 4 bytes in order.
- Model asserts finished on pixel 5 -> frame_err=1; frame still emits 4 bytes with eof on byte 3.
- Reset during WAIT_DONE of pixel 3 -> outputs zero next cycle. Then start -> DRAIN waits until running=0, and the frame starts with a sof byte.
- start pulsed while busy -> ignored; exactly one frame_done.
- out_ready toggling each cycle -> no byte lost or duplicated; occupancy never exceeds FIFO_DEPTH.
